// File: rtl/ddram_arb_pkg.sv
// Shared types and defaults for the two-port DDR3 Avalon-MM arbiter.
//   arb_state_t : arbiter phase (idle, write burst, read command, read data)
//   port_idx_t  : requester index, 0 or 1
//   *_DEF       : default address / data / burstcount widths
package ddram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RCMD = 2'd2,
        RDAT = 2'd3
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int AW_DEF  = 29;
    localparam int DW_DEF  = 64;
    localparam int BCW_DEF = 8;

endpackage

// File: rtl/ddram_arb_rr.sv
// Two-way grant unit for the DDR3 arbiter.
//   req      in   2  pending request per port
//   rr_next  in   1  port preferred on a simultaneous request (RR != 0 only)
//   gnt_vld  out  1  at least one port is requesting
//   gnt      out  1  winning port index
// RR != 0 : round-robin, a tie goes to rr_next.
// RR == 0 : fixed priority, port 0 wins whenever it requests.
module ddram_arb_rr
    import ddram_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic [1:0] req,
    input  port_idx_t  rr_next,
    output logic       gnt_vld,
    output port_idx_t  gnt
);

    always_comb begin
        gnt_vld = |req;
        gnt     = 1'b0;
        if (req == 2'b11) begin
            gnt = (RR != 0) ? rr_next : 1'b0;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/ddram_arbiter2.sv
// Two-port arbiter sharing one 64-bit DDR3 Avalon-MM master (ram_*) between
// two requesters (p0, p1). A grant is held for the whole burst: until every
// write beat is accepted, or every read beat has been returned.
//   ram_clk, reset_n        clock, asynchronous active-low reset
//   pN_address/burstcount   requester N command (sampled when granted)
//   pN_read/write           requester N read request / write beat
//   pN_writedata/byteenable requester N write beat payload
//   pN_waitrequest          stall to requester N (1 whenever N is not owner)
//   pN_readdata/valid       shared read data, per-port valid
//   ram_*                   master side towards the HPS memory bridge
module ddram_arbiter2
    import ddram_arb_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int BCW = BCW_DEF,
    parameter int RR  = 1
) (
    input  logic            ram_clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   p0_address,
    input  logic [BCW-1:0]  p0_burstcount,
    input  logic            p0_read,
    input  logic            p0_write,
    input  logic [DW-1:0]   p0_writedata,
    input  logic [DW/8-1:0] p0_byteenable,
    output logic            p0_waitrequest,
    output logic [DW-1:0]   p0_readdata,
    output logic            p0_readdatavalid,

    input  logic [AW-1:0]   p1_address,
    input  logic [BCW-1:0]  p1_burstcount,
    input  logic            p1_read,
    input  logic            p1_write,
    input  logic [DW-1:0]   p1_writedata,
    input  logic [DW/8-1:0] p1_byteenable,
    output logic            p1_waitrequest,
    output logic [DW-1:0]   p1_readdata,
    output logic            p1_readdatavalid,

    output logic [AW-1:0]   ram_address,
    output logic [BCW-1:0]  ram_burstcount,
    output logic            ram_read,
    output logic            ram_write,
    output logic [DW-1:0]   ram_writedata,
    output logic [DW/8-1:0] ram_byteenable,
    input  logic            ram_waitrequest,
    input  logic [DW-1:0]   ram_readdata,
    input  logic            ram_readdatavalid
);

    // A burstcount of 0 still moves one beat.
    function automatic logic [BCW-1:0] burst_beats(input logic [BCW-1:0] bc);
        return (bc == '0) ? BCW'(1) : bc;
    endfunction

    arb_state_t      state, state_d;
    port_idx_t       owner, rr_next, gnt;
    logic            gnt_vld;
    logic            granted;
    logic [BCW-1:0]  bcnt;
    logic [AW-1:0]   addr_q;
    logic [BCW-1:0]  bc_q;

    logic            own_write, own_wait, own_rdv, beat_done;
    logic [DW-1:0]   own_wdata;
    logic [DW/8-1:0] own_be;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [BCW-1:0]  sel_bc;

    ddram_arb_rr #(.RR(RR)) u_rr (
        .req     ({p1_read | p1_write, p0_read | p0_write}),
        .rr_next (rr_next),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    // Command of the port being granted this cycle (only used in IDLE).
    assign sel_write = gnt ? p1_write      : p0_write;
    assign sel_addr  = gnt ? p1_address    : p0_address;
    assign sel_bc    = gnt ? p1_burstcount : p0_burstcount;

    // Beat-level signals of the current owner.
    assign own_write = owner ? p1_write     : p0_write;
    assign own_wdata = owner ? p1_writedata : p0_writedata;
    assign own_be    = owner ? p1_byteenable : p0_byteenable;

    always_comb begin
        state_d   = state;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        own_wait  = 1'b1;
        own_rdv   = 1'b0;
        beat_done = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) state_d = sel_write ? WR : RCMD;
            end
            WR: begin
                ram_write = own_write;
                own_wait  = ram_waitrequest;
                if (own_write && !ram_waitrequest) begin
                    beat_done = 1'b1;
                    if (bcnt == BCW'(1)) state_d = IDLE;
                end
            end
            RCMD: begin
                ram_read = 1'b1;
                own_wait = ram_waitrequest;
                if (!ram_waitrequest) state_d = RDAT;
            end
            RDAT: begin
                own_rdv = ram_readdatavalid;
                if (ram_readdatavalid) begin
                    beat_done = 1'b1;
                    if (bcnt == BCW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_next <= 1'b0;
            granted <= 1'b0;
            bcnt    <= '0;
            addr_q  <= '0;
            bc_q    <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && gnt_vld) begin
                owner   <= gnt;
                granted <= 1'b1;
                bcnt    <= burst_beats(sel_bc);
                addr_q  <= sel_addr;
                bc_q    <= sel_bc;
            end else if (beat_done) begin
                bcnt <= bcnt - BCW'(1);
            end
            if (state != IDLE && state_d == IDLE) rr_next <= ~owner;
        end
    end

    // Address/burstcount are registered at grant, so nothing from pN_* reaches
    // ram_* combinationally while idle. Write data follows the owner, but is
    // held at zero until the first grant after reset.
    assign ram_address    = addr_q;
    assign ram_burstcount = bc_q;
    assign ram_writedata  = granted ? own_wdata : '0;
    assign ram_byteenable = granted ? own_be    : '0;

    assign p0_waitrequest   = (owner == 1'b0) ? own_wait : 1'b1;
    assign p1_waitrequest   = (owner == 1'b1) ? own_wait : 1'b1;
    assign p0_readdatavalid = (owner == 1'b0) && own_rdv;
    assign p1_readdatavalid = (owner == 1'b1) && own_rdv;
    assign p0_readdata      = ram_readdata;
    assign p1_readdata      = ram_readdata;

endmodule
